// File: rtl/grf_write_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, late results
// (mul/div) wait in a 2-entry FIFO with starvation-driven stall and ordering checks.
module grf_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_i_valid,
  input  logic [4:0]  wb_i_addr,
  input  logic [31:0] wb_i_data,
  input  logic [31:0] wb_i_pc,
  input  logic        md_i_valid,
  output logic        md_o_ready,
  input  logic [4:0]  md_i_addr,
  input  logic [31:0] md_i_data,
  input  logic [31:0] md_i_pc,
  output logic        grf_o_we,
  output logic [4:0]  grf_o_waddr,
  output logic [31:0] grf_o_wdata,
  output logic [31:0] grf_o_pc,
  output logic [31:0] busy_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

  logic [4:0]  q_addr [2];
  logic [31:0] q_data [2];
  logic [31:0] q_pc   [2];
  logic [1:0]  count;
  logic [3:0]  starve;

  logic wb_eff, pop, enq, hit, v0, v1, wr_slot;
  logic [1:0] count_after_pop;

  always_comb begin
    v0              = (count != 2'd0);
    v1              = (count == 2'd2);
    wb_eff          = wb_i_valid && (wb_i_addr != 5'd0);
    pop             = !wb_eff && v0;
    md_o_ready      = (count != 2'd2);
    enq             = md_i_valid && md_o_ready && (md_i_addr != 5'd0);
    count_after_pop = count - {1'b0, pop};
    wr_slot         = count_after_pop[0];
    hit             = (v0 && (q_addr[0] == wb_i_addr)) || (v1 && (q_addr[1] == wb_i_addr));
    stall_o         = (starve == LIMIT);
  end

  always_comb begin
    busy_o = '0;
    if (v0) busy_o[q_addr[0]] = 1'b1;
    if (v1) busy_o[q_addr[1]] = 1'b1;
    busy_o[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      starve      <= '0;
      grf_o_we    <= 1'b0;
      grf_o_waddr <= '0;
      grf_o_wdata <= '0;
      grf_o_pc    <= '0;
      err_o       <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      grf_o_we <= wb_eff || pop;
      if (wb_eff) begin
        grf_o_waddr <= wb_i_addr;
        grf_o_wdata <= wb_i_data;
        grf_o_pc    <= wb_i_pc;
      end else if (pop) begin
        grf_o_waddr <= q_addr[0];
        grf_o_wdata <= q_data[0];
        grf_o_pc    <= q_pc[0];
      end
      if (wb_eff && (hit || stall_o)) err_o <= 1'b1;

      // Pop shifts entry 1 into the head; a same-edge enqueue into slot 0 overrides it.
      if (pop) begin
        q_addr[0] <= q_addr[1];
        q_data[0] <= q_data[1];
        q_pc[0]   <= q_pc[1];
      end
      if (enq) begin
        q_addr[wr_slot] <= md_i_addr;
        q_data[wr_slot] <= md_i_data;
        q_pc[wr_slot]   <= md_i_pc;
      end
      count <= count_after_pop + {1'b0, enq};

      if (!v0 || pop)        starve <= '0;
      else if (starve != LIMIT) starve <= starve + 4'd1;
    end
  end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Randomized bench for grf_write_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_grf_write_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_i_valid = 1'b0;
  logic [4:0]  wb_i_addr = '0;
  logic [31:0] wb_i_data = '0, wb_i_pc = '0;
  logic        md_i_valid = 1'b0;
  logic [4:0]  md_i_addr = '0;
  logic [31:0] md_i_data = '0, md_i_pc = '0;
  logic        md_o_ready, grf_o_we, stall_o, err_o;
  logic [4:0]  grf_o_waddr;
  logic [31:0] grf_o_wdata, grf_o_pc, busy_o;

  int errors = 0;
  int checks = 0;

  grf_write_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .wb_i_valid(wb_i_valid), .wb_i_addr(wb_i_addr), .wb_i_data(wb_i_data), .wb_i_pc(wb_i_pc),
    .md_i_valid(md_i_valid), .md_o_ready(md_o_ready),
    .md_i_addr(md_i_addr), .md_i_data(md_i_data), .md_i_pc(md_i_pc),
    .grf_o_we(grf_o_we), .grf_o_waddr(grf_o_waddr), .grf_o_wdata(grf_o_wdata), .grf_o_pc(grf_o_pc),
    .busy_o(busy_o), .stall_o(stall_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the FIFO is a plain queue of pending writes.
  typedef struct packed { logic [4:0] addr; logic [31:0] data; logic [31:0] pc; } entry_t;
  entry_t      m_q[$];
  int          m_starve = 0;
  logic        m_we = 1'b0, m_err = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0, m_pc = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_starve = 0; m_we = 1'b0; m_err = 1'b0;
      m_addr = '0; m_data = '0; m_pc = '0;
    end else begin
      bit wb_eff, ready, stalled, hit;
      entry_t e;
      wb_eff  = wb_i_valid && (wb_i_addr != 0);
      ready   = m_q.size() < 2;
      stalled = (m_starve == LIM);
      hit     = 1'b0;
      foreach (m_q[i]) if (m_q[i].addr == wb_i_addr) hit = 1'b1;
      if (wb_eff) begin
        m_we = 1'b1; m_addr = wb_i_addr; m_data = wb_i_data; m_pc = wb_i_pc;
        if (hit || stalled) m_err = 1'b1;
        if (m_q.size() > 0) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
        else m_starve = 0;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_we = 1'b1; m_addr = e.addr; m_data = e.data; m_pc = e.pc;
        m_starve = 0;
      end else begin
        m_we = 1'b0; m_starve = 0;
      end
      if (md_i_valid && ready && md_i_addr != 0)
        m_q.push_back('{addr: md_i_addr, data: md_i_data, pc: md_i_pc});
    end
  end

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    foreach (m_q[i]) b[m_q[i].addr] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  always @(negedge clk) begin
    check("we",    {31'd0, grf_o_we},   {31'd0, m_we});
    check("waddr", {27'd0, grf_o_waddr}, {27'd0, m_addr});
    check("wdata", grf_o_wdata, m_data);
    check("pc",    grf_o_pc,    m_pc);
    check("ready", {31'd0, md_o_ready}, {31'd0, m_q.size() < 2});
    check("busy",  busy_o, m_busy());
    check("stall", {31'd0, stall_o}, {31'd0, m_starve == LIM});
    check("err",   {31'd0, err_o},   {31'd0, m_err});
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    wb_i_valid = 1'b0; md_i_valid = 1'b0;
  endtask

  task automatic drive_wb(input logic [4:0] a, input logic [31:0] d);
    wb_i_valid = 1'b1; wb_i_addr = a; wb_i_data = d; wb_i_pc = d ^ 32'h5A5A_0000;
  endtask

  task automatic drive_md(input logic [4:0] a, input logic [31:0] d);
    md_i_valid = 1'b1; md_i_addr = a; md_i_data = d; md_i_pc = 32'h4000 + {27'd0, a};
  endtask

  task automatic do_reset();
    tick(); reset = 1'b0; idle();
    tick(); reset = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b0;
    tick();
    check("rst_ready", {31'd0, md_o_ready}, 32'd1);
    check("rst_we",    {31'd0, grf_o_we},   32'd0);
    check("rst_busy",  busy_o, 32'd0);
    tick(); reset = 1'b1;

    // Write-back only
    drive_wb(5'd5, 32'h1234_5678);
    tick(); idle();
    check("wb_we",    {31'd0, grf_o_we}, 32'd1);
    check("wb_addr",  {27'd0, grf_o_waddr}, 32'd5);
    check("wb_data",  grf_o_wdata, 32'h1234_5678);
    tick();
    check("wb_idle",  {31'd0, grf_o_we}, 32'd0);
    check("wb_hold",  grf_o_wdata, 32'h1234_5678);

    // Late result through an idle write port
    drive_md(5'd8, 32'hA);
    tick(); idle();
    check("md_busy",  busy_o, 32'h100);
    check("md_we0",   {31'd0, grf_o_we}, 32'd0);
    tick();
    check("md_we",    {31'd0, grf_o_we}, 32'd1);
    check("md_addr",  {27'd0, grf_o_waddr}, 32'd8);
    check("md_data",  grf_o_wdata, 32'hA);
    check("md_busy0", busy_o, 32'd0);

    // Backpressure
    drive_wb(5'd3, 32'h33); drive_md(5'd10, 32'h1010);
    tick();
    check("bp_ready1", {31'd0, md_o_ready}, 32'd1);
    check("bp_busy1",  busy_o, 32'h400);
    drive_md(5'd11, 32'h1111);
    tick();
    check("bp_ready2", {31'd0, md_o_ready}, 32'd0);
    check("bp_busy2",  busy_o, 32'hC00);
    drive_md(5'd12, 32'h1212);
    tick();
    check("bp_ready3", {31'd0, md_o_ready}, 32'd0);
    tick();
    check("bp_busy4",  busy_o, 32'hC00);
    wb_i_valid = 1'b0;
    tick();
    check("bp_pop10",  {27'd0, grf_o_waddr}, 32'd10);
    check("bp_ready5", {31'd0, md_o_ready}, 32'd1);
    check("bp_busy5",  busy_o, 32'h800);
    tick(); idle();
    check("bp_pop11",  {27'd0, grf_o_waddr}, 32'd11);
    check("bp_busy6",  busy_o, 32'h1000);
    tick();
    check("bp_pop12",  grf_o_wdata, 32'h1212);
    check("bp_err",    {31'd0, err_o}, 32'd0);

    // Starvation
    drive_wb(5'd3, 32'h77); drive_md(5'd7, 32'h7777);
    tick(); md_i_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("starve_stall", {31'd0, stall_o}, {31'd0, i == 4});
    end
    wb_i_valid = 1'b0;
    tick();
    check("starve_pop",   {27'd0, grf_o_waddr}, 32'd7);
    check("starve_clear", {31'd0, stall_o}, 32'd0);
    check("starve_err",   {31'd0, err_o}, 32'd0);

    // Zero address discard and ordering violation
    do_reset();
    drive_md(5'd0, 32'hDEAD);
    tick();
    check("zero_busy", busy_o, 32'd0);
    drive_md(5'd9, 32'h9999);
    tick();
    check("zero_we",   {31'd0, grf_o_we}, 32'd0);
    check("ord_busy",  busy_o, 32'h200);
    md_i_valid = 1'b0; drive_wb(5'd9, 32'h9090);
    tick(); idle();
    check("ord_err",   {31'd0, err_o}, 32'd1);
    check("ord_wdata", grf_o_wdata, 32'h9090);
    tick();
    check("ord_drain", grf_o_wdata, 32'h9999);
    tick();
    check("ord_sticky", {31'd0, err_o}, 32'd1);

    // Reset with two entries queued
    do_reset();
    drive_wb(5'd3, 32'h3); drive_md(5'd4, 32'h44);
    tick(); drive_md(5'd5, 32'h55);
    tick(); md_i_valid = 1'b0;
    check("rq_full", {31'd0, md_o_ready}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("rq_ready", {31'd0, md_o_ready}, 32'd1);
    check("rq_busy",  busy_o, 32'd0);
    check("rq_we",    {31'd0, grf_o_we}, 32'd0);
    check("rq_err",   {31'd0, err_o}, 32'd0);
    drive_md(5'd6, 32'h66);
    tick(); reset = 1'b1; idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rq_nowrite", {31'd0, grf_o_we}, 32'd0);
    end

    // Randomized traffic with occasional mid-run reset
    for (int n = 0; n < 4000; n++) begin
      int wb_pct;
      wb_pct = ((n / 500) % 2 == 0) ? 40 : 85;
      reset = ($urandom_range(0, 249) != 0);
      wb_i_valid = ($urandom_range(0, 99) < wb_pct);
      wb_i_addr  = 5'($urandom_range(0, 7));
      wb_i_data  = $urandom; wb_i_pc = $urandom;
      md_i_valid = ($urandom_range(0, 1) == 1);
      md_i_addr  = 5'($urandom_range(0, 7));
      md_i_data  = $urandom; md_i_pc = $urandom;
      tick();
    end
    reset = 1'b1; idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
